// File: rtl/peg_l2_mac_tx_preamble.sv
// MAC TX preamble stage: prepends the preamble/SFD word, checks beat count vs
// declared size, drains malformed frames and enforces an inter-packet gap.
module peg_l2_mac_tx_preamble #(
  parameter int PKT_DATA_W = 64,
  parameter int PKT_SIZE_W = 16,
  parameter int IPG_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [PKT_DATA_W-1:0] in_data,
  input  logic [PKT_SIZE_W-1:0] in_size,
  input  logic                  in_error,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [PKT_DATA_W-1:0] out_data,
  output logic [PKT_SIZE_W-1:0] out_size,
  output logic                  out_error,
  input  logic                  out_ready,
  output logic                  stat_drop,
  output logic                  stat_len_err
);
  localparam logic [PKT_DATA_W-1:0] PREAMBLE = PKT_DATA_W'(64'hD555_5555_5555_5555);
  localparam int EW = PKT_SIZE_W - 2;
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [PKT_SIZE_W-1:0] MAX_SIZE = PKT_SIZE_W'((1 << PKT_SIZE_W) - 9);
  localparam logic [PKT_SIZE_W-1:0] PRE_BYTES = PKT_SIZE_W'(8);

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, GAP} state_t;

  state_t                  state, state_d;
  logic [PKT_SIZE_W-1:0]   size_q;
  logic [EW-1:0]           exp_q, wcnt;
  logic [GW-1:0]           gcnt;
  logic                    err_q, orphan_q, orphan_d;
  logic                    cap, adv, last, sop_legal;
  logic                    o_valid, o_sop, o_eop, o_err, i_rdy, drop, lerr;
  logic [PKT_DATA_W-1:0]   o_data;
  logic [PKT_SIZE_W-1:0]   o_size;

  assign sop_legal = (in_size != '0) && (in_size <= MAX_SIZE);
  assign last      = (wcnt == exp_q - 1'b1);

  always_comb begin
    state_d  = state;
    orphan_d = orphan_q;
    o_valid  = 1'b0;
    o_sop    = 1'b0;
    o_eop    = 1'b0;
    o_err    = 1'b0;
    o_data   = '0;
    o_size   = '0;
    i_rdy    = 1'b0;
    drop     = 1'b0;
    lerr     = 1'b0;
    cap      = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        if (in_sop) begin
          orphan_d = 1'b0;
          if (sop_legal) begin
            // preamble is emitted in place of the sop beat, which stays pending
            o_valid = 1'b1;
            o_sop   = 1'b1;
            o_data  = PREAMBLE;
            o_size  = in_size + PRE_BYTES;
            if (out_ready) begin
              cap     = 1'b1;
              state_d = DATA;
            end
          end else begin
            i_rdy = 1'b1;
            drop  = 1'b1;
            if (!in_eop) state_d = DRAIN;
          end
        end else begin
          // headless beats: one drop pulse per run until the next sop
          i_rdy    = 1'b1;
          drop     = !orphan_q;
          orphan_d = 1'b1;
        end
      end
      DATA: begin
        o_valid = in_valid;
        i_rdy   = out_ready;
        o_data  = in_data;
        o_size  = size_q + PRE_BYTES;
        if (in_valid) begin
          o_eop = last | in_eop;
          if (last)        o_err = err_q | in_error | !in_eop;
          else if (in_eop) o_err = 1'b1;
          if (out_ready) begin
            adv  = 1'b1;
            lerr = last ^ in_eop;
            if (last && !in_eop)     state_d = DRAIN;
            else if (last || in_eop) state_d = (IPG_CYCLES == 0) ? IDLE : GAP;
          end
        end
      end
      DRAIN: begin
        i_rdy = 1'b1;
        if (in_valid && in_eop) state_d = IDLE;
      end
      GAP: if (gcnt == GW'(IPG_CYCLES - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      size_q   <= '0;
      exp_q    <= '0;
      wcnt     <= '0;
      gcnt     <= '0;
      err_q    <= 1'b0;
      orphan_q <= 1'b0;
    end else begin
      state    <= state_d;
      orphan_q <= orphan_d;
      if (cap) begin
        size_q <= in_size;
        exp_q  <= EW'((in_size + PKT_SIZE_W'(7)) >> 3);
        wcnt   <= '0;
        err_q  <= 1'b0;
      end else if (adv) begin
        wcnt  <= wcnt + 1'b1;
        err_q <= err_q | in_error;
      end
      gcnt <= (state == GAP) ? gcnt + 1'b1 : '0;
    end
  end

  // outputs are combinational, so reset has to force them low explicitly
  assign out_valid    = rst_n & o_valid;
  assign out_sop      = rst_n & o_sop;
  assign out_eop      = rst_n & o_eop;
  assign out_error    = rst_n & o_err;
  assign in_ready     = rst_n & i_rdy;
  assign stat_drop    = rst_n & drop;
  assign stat_len_err = rst_n & lerr;
  assign out_data     = rst_n ? o_data : '0;
  assign out_size     = rst_n ? o_size : '0;
endmodule
